alu_mb_sequencer: RTL and testbench
===================================

# alu_mb_sequencer

Multi-byte arithmetic/logic sequencer for the 8-bit ALU. It accepts one NUM_BYTES-wide operation per handshake and drives the shared combinational ALU one byte per cycle, low byte first. Carries and borrows between bytes are handled with INC/DEC fix-up passes. It returns the assembled result with whole-word NZVC flags. It sits between the core's execute stage and the ALU instance and owns the ALU inputs exclusively.

## Interface
- NUM_BYTES, 2, operand width in bytes; legal range 2..4; W = 8*NUM_BYTES.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  ALU_Sel encoding: 0 ADD, 1 SUB, 4 BAND, 5 BOR, 6 XOR, 7 INC, 8 DEC; all other codes are illegal.
- req_a, req_b  in  W  operands; req_b is ignored for INC/DEC.
- resp_valid  out  1  result available; held until accepted.
- resp_ready  in  1  consumer accepts the result.
- resp_result  out  W  result word.
- resp_nzvc  out  4  {N,Z,V,C} for the whole word.
- resp_err  out  1  illegal opcode.
- alu_a, alu_b  out  8  ALU operand inputs.
- alu_sel  out  4  ALU operation select.
- alu_result  in  8  ALU result, combinational, same cycle.
- alu_nzvc  in  4  ALU flags; only bit 0 (carry/borrow) is used.

## Operation
- States: IDLE, BYTE_OP, FIXUP, DONE.
- IDLE:
  - req_ready=1; ALU outputs driven 0.
  - On req_valid: latch op and operands, clear carry, set byte index i=0.
  - Legal op -> BYTE_OP. Illegal op -> DONE with resp_err=1, result 0, nzvc 0000.
- Internal op mapping: INC is run as ADD with b=1; DEC is run as SUB with b=1.
- BYTE_OP, byte i:
  - Drive alu_a=A[i], alu_b=B[i]. alu_sel = ADD for ADD/INC, SUB for SUB/DEC, otherwise the op itself.
  - Store alu_result into R[i] and store c1=alu_nzvc[0]. Logic ops force c1=0.
  - If pending carry and op is arithmetic -> FIXUP.
  - Else set carry=c1; then i++ -> BYTE_OP, or if i was the last byte -> DONE.
- FIXUP, byte i:
  - Drive alu_a=R[i], alu_b=0, alu_sel = INC (7) for additive ops, DEC (8) for subtractive ops.
  - Store R[i]=alu_result; carry = c1 | alu_nzvc[0].
  - Then i++ -> BYTE_OP, or if last byte -> DONE.
- Byte 0 never takes FIXUP.
- Flags, computed on entry to DONE:
  - N = R[W-1].
  - Z = (R == 0).
  - C = final carry/borrow out of the top byte; 0 for logic ops.
  - V, additive ops: (A[W-1]==B'[W-1]) & (R[W-1]!=A[W-1]), where B' is the effective b (1 for INC/DEC).
  - V, subtractive ops: (A[W-1]!=B'[W-1]) & (R[W-1]!=A[W-1]).
  - V = 0 for logic ops.
- DONE: resp_valid=1 with result, flags and err stable; on resp_ready -> IDLE.
- Reset, asynchronous and including mid-operation: state=IDLE and all registers cleared.
  - Reset values: resp_valid=0, resp_result=0, resp_nzvc=0, resp_err=0, alu_a=alu_b=alu_sel=0, req_ready=1.

## Timing
- The request is accepted on the edge where req_valid & req_ready are both high. A new request cannot be accepted in the cycle that DONE is left.
- Latency from accept edge to resp_valid high = NUM_BYTES + (number of FIXUP passes) edges.
  - Maximum latency: 2*NUM_BYTES-1 edges.
  - Illegal op: 1 edge.
- One ALU pass per cycle; ALU outputs change only on clock edges.
- resp_valid falls on the edge after resp_ready is sampled high; with resp_ready held high, DONE lasts exactly one cycle.
- Operands and op are sampled only at accept; input changes afterwards have no effect.

## Test plan
Use NUM_BYTES=2; accept edge = E0.
- ADD 0x00FF+0x0001 -> resp 0x0100, nzvc 0000, resp_valid after E3; alu_sel sequence 0,0,7.
- SUB 0x0000-0x0001 -> 0xFFFF, nzvc 1001, after E3; fix-up uses alu_sel=8.
- ADD 0x7FFF+0x0001 -> 0x8000, nzvc 1010; INC 0xFFFF -> 0x0000, nzvc 0101.
- XOR 0xA5A5^0xA5A5 -> 0x0000, nzvc 0100, after E2; op 2 (LAND) -> resp_err=1, result 0, after E1.
- Hold resp_ready low 5 cycles after DONE -> resp_valid and data stay stable and req_ready stays 0; release -> IDLE next edge, and a back-to-back request is accepted.
- Assert reset_n low during FIXUP -> all outputs reset at once; after release, SUB 0x1234-0x0234 -> 0x1000, nzvc 0000.

Source files
------------

// File: rtl/alu_mb_sequencer.sv
// rtl/alu_mb_sequencer.sv - multi-byte op sequencer driving a shared 8-bit ALU
// Runs one byte per cycle, low byte first, using INC/DEC passes to ripple carries.
module alu_mb_sequencer #(
  parameter int NUM_BYTES = 2,
  localparam int W = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_result,
  output logic [3:0]   resp_nzvc,
  output logic         resp_err,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_sel,
  input  logic [7:0]   alu_result,
  input  logic [3:0]   alu_nzvc
);

  typedef enum logic [1:0] {IDLE, BYTE_OP, FIXUP, DONE} state_t;

  state_t       state;
  logic [3:0]   op;
  logic [W-1:0] a_q, b_q, r_q;
  logic         carry, c1, err;
  logic [1:0]   idx;

  logic         is_add, is_sub, arith, last, c_byte, c_fix, ovf, done_c;
  logic [1:0]   nidx;
  logic [3:0]   byte_sel, nzvc_done;
  logic [W-1:0] r_upd, req_b_eff;
  logic [7:0]   a_next, b_next;
  logic         unused_flags;

  function automatic logic legal_op(input logic [3:0] o);
    return (o == 4'd0) || (o == 4'd1) || (o == 4'd4) || (o == 4'd5) ||
           (o == 4'd6) || (o == 4'd7) || (o == 4'd8);
  endfunction

  // INC/DEC are executed as ADD/SUB against an effective b of 1
  function automatic logic [3:0] map_sel(input logic [3:0] o);
    if (o == 4'd0 || o == 4'd7) return 4'd0;
    if (o == 4'd1 || o == 4'd8) return 4'd1;
    return o;
  endfunction

  assign req_ready    = (state == IDLE);
  assign unused_flags = ^alu_nzvc[3:1];

  assign is_add    = (op == 4'd0) || (op == 4'd7);
  assign is_sub    = (op == 4'd1) || (op == 4'd8);
  assign arith     = is_add | is_sub;
  assign last      = (idx == 2'(NUM_BYTES - 1));
  assign nidx      = idx + 2'd1;
  assign c_byte    = arith & alu_nzvc[0];
  assign c_fix     = c1 | alu_nzvc[0];
  assign byte_sel  = map_sel(op);
  assign req_b_eff = (req_op == 4'd7 || req_op == 4'd8) ? W'(1) : req_b;

  always_comb begin
    r_upd  = r_q;
    a_next = '0;
    b_next = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx == 2'(k)) r_upd[8*k +: 8] = alu_result;
      if (nidx == 2'(k)) begin
        a_next = a_q[8*k +: 8];
        b_next = b_q[8*k +: 8];
      end
    end
  end

  assign done_c = (state == FIXUP) ? c_fix : c_byte;
  assign ovf    = is_add ? ((a_q[W-1] == b_q[W-1]) && (r_upd[W-1] != a_q[W-1])) :
                  is_sub ? ((a_q[W-1] != b_q[W-1]) && (r_upd[W-1] != a_q[W-1])) : 1'b0;
  assign nzvc_done = {r_upd[W-1], (r_upd == '0), ovf, done_c};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      carry       <= 1'b0;
      c1          <= 1'b0;
      err         <= 1'b0;
      idx         <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_nzvc   <= '0;
      resp_err    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op    <= req_op;
            a_q   <= req_a;
            b_q   <= req_b_eff;
            r_q   <= '0;
            carry <= 1'b0;
            c1    <= 1'b0;
            idx   <= '0;
            err   <= !legal_op(req_op);
            // an illegal op still spends one pass in BYTE_OP with the ALU held at 0
            state <= BYTE_OP;
            if (legal_op(req_op)) begin
              alu_a   <= req_a[7:0];
              alu_b   <= req_b_eff[7:0];
              alu_sel <= map_sel(req_op);
            end
          end
        end
        BYTE_OP, FIXUP: begin
          if (err) begin
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_result <= '0;
            resp_nzvc   <= '0;
            resp_err    <= 1'b1;
          end else if (state == BYTE_OP && carry && arith) begin
            r_q     <= r_upd;
            c1      <= c_byte;
            state   <= FIXUP;
            alu_a   <= alu_result;
            alu_b   <= '0;
            alu_sel <= is_sub ? 4'd8 : 4'd7;
          end else begin
            r_q <= r_upd;
            if (state == BYTE_OP) c1 <= c_byte;
            carry <= done_c;
            if (last) begin
              state       <= DONE;
              resp_valid  <= 1'b1;
              resp_result <= r_upd;
              resp_nzvc   <= nzvc_done;
              resp_err    <= 1'b0;
              alu_a       <= '0;
              alu_b       <= '0;
              alu_sel     <= '0;
            end else begin
              state   <= BYTE_OP;
              idx     <= nidx;
              alu_a   <= a_next;
              alu_b   <= b_next;
              alu_sel <= byte_sel;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mb_sequencer.sv
// tb/tb_alu_mb_sequencer.sv - self-checking bench for alu_mb_sequencer
// Word-level arithmetic reference model plus a behavioural 8-bit ALU.
module tb_alu_mb_sequencer;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [3:0]   req_op, resp_nzvc, alu_sel, alu_nzvc;
  logic [W-1:0] req_a, req_b, resp_result;
  logic [7:0]   alu_a, alu_b, alu_result;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [3:0]   sels[$];
  logic [W-1:0] last_res;
  logic [3:0]   last_nzvc;
  int           last_lat;

  always #5 clk = ~clk;

  alu_mb_sequencer #(.NUM_BYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_nzvc(resp_nzvc), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_nzvc(alu_nzvc)
  );

  // Shared 8-bit ALU; bit 0 of the flags is carry (ADD/INC) or borrow (SUB/DEC)
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_sel)
      4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: t = {(alu_a < alu_b), alu_a - alu_b};
      4'd4: t = {1'b0, alu_a & alu_b};
      4'd5: t = {1'b0, alu_a | alu_b};
      4'd6: t = {1'b0, alu_a ^ alu_b};
      4'd7: t = {(alu_a == 8'hFF), alu_a + 8'd1};
      4'd8: t = {(alu_a == 8'h00), alu_a - 8'd1};
      default: t = '0;
    endcase
    alu_result = t[7:0];
    alu_nzvc   = {t[7], (t[7:0] == 8'h00), 1'b0, t[8]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level model: fix-up count = number of upper bytes receiving a carry/borrow in
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f, output logic e,
                       output int lat);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         c, v, add, sub;
    longint       mask;
    add = (op == 4'd0) || (op == 4'd7);
    sub = (op == 4'd1) || (op == 4'd8);
    bb  = (op == 4'd7 || op == 4'd8) ? W'(1) : b;
    e = 1'b0; c = 1'b0; v = 1'b0; r = '0; lat = NB;
    case (op)
      4'd0, 4'd7: begin s = {1'b0, a} + {1'b0, bb}; r = s[W-1:0]; c = s[W]; end
      4'd1, 4'd8: begin r = a - bb; c = (a < bb); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      default: e = 1'b1;
    endcase
    if (add) v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    if (sub) v = (a[W-1] != bb[W-1]) && (r[W-1] != a[W-1]);
    f = {r[W-1], (r == '0), v, c};
    for (int i = 1; i < NB; i++) begin
      mask = (64'd1 << (8 * i)) - 1;
      if (add && ((longint'(a) & mask) + (longint'(bb) & mask)) > mask) lat++;
      if (sub && ((longint'(a) & mask) < (longint'(bb) & mask))) lat++;
    end
    if (e) begin r = '0; f = '0; lat = 1; end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic         ee;
    int           el, lat, n;
    model(op, a, b, er, ef, ee, el);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = W'($urandom); req_b = W'($urandom);
    sels.delete();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      sels.push_back(alu_sel);
      @(posedge clk);
      lat++;
    end
    check("latency", lat, el);
    check("result", resp_result, er);
    check("nzvc", resp_nzvc, ef);
    check("err", resp_err, ee);
    last_res = resp_result; last_nzvc = resp_nzvc; last_lat = lat;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_result", resp_result, er);
      check("hold_nzvc", resp_nzvc, ef);
      check("hold_ready_low", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", resp_valid, 0);
    check("back_to_idle", req_ready, 1);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] ops[10];
    int n;
    ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd9, 4'd15};
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    #2;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_nzvc", resp_nzvc, 0);
    check("rst_err", resp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(4'd0, 16'h00FF, 16'h0001, 0);
    check("add_carry_res", last_res, 16'h0100);
    check("add_carry_lat", last_lat, 3);
    check("add_sel_n", sels.size(), 3);
    if (sels.size() == 3) begin
      check("add_sel0", sels[0], 0);
      check("add_sel1", sels[1], 0);
      check("add_sel2", sels[2], 7);
    end
    run_op(4'd1, 16'h0000, 16'h0001, 0);
    check("sub_borrow_res", last_res, 16'hFFFF);
    check("sub_borrow_nzvc", last_nzvc, 4'b1001);
    check("sub_fix_sel", (sels.size() == 3) ? 32'(sels[2]) : 32'hFFFF, 8);
    run_op(4'd0, 16'h7FFF, 16'h0001, 0);
    check("add_ovf_nzvc", last_nzvc, 4'b1010);
    run_op(4'd7, 16'hFFFF, 16'h1234, 0);
    check("inc_wrap_nzvc", last_nzvc, 4'b0101);
    run_op(4'd6, 16'hA5A5, 16'hA5A5, 0);
    check("xor_nzvc", last_nzvc, 4'b0100);
    check("xor_lat", last_lat, 2);
    run_op(4'd2, 16'h1234, 16'h5678, 0);
    check("illegal_lat", last_lat, 1);

    run_op(4'd1, 16'h8000, 16'h0001, 5);
    run_op(4'd0, 16'h1111, 16'h2222, 0);

    req_valid = 1'b1; req_op = 4'd1; req_a = 16'h0000; req_b = 16'h0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (alu_sel !== 4'd8 && n < 10) begin @(negedge clk); n++; end
    check("reach_fixup", alu_sel, 8);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_result", resp_result, 0);
    check("mid_rst_nzvc", resp_nzvc, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_sel", alu_sel, 0);
    check("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(4'd1, 16'h1234, 16'h0234, 0);
    check("post_rst_res", last_res, 16'h1000);
    check("post_rst_nzvc", last_nzvc, 4'b0000);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (t % 4 == 0) ra[7:0] = 8'hFF;
      run_op(ops[$urandom_range(0, 9)], ra, rb, (t % 7 == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
